// File: rtl/dev_alarm_pkg.sv
// Purpose: shared widths, FSM state encoding and a saturating-increment helper for dev_alarm.
// Latency: n/a (types and constants only).
// Backpressure: n/a; dev_alarm always accepts samples.
package dev_alarm_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;
    localparam int RUN_W  = 4;

    typedef enum logic [2:0] {
        ST_WARM    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SUSPECT = 3'd2,
        ST_ALARM   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    // The event counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dev_alarm_if.sv
// Purpose: sample/mean input bundle and alarm result bundle for dev_alarm.
// Latency: n/a (wiring only).
// Backpressure: none; in_vld is a plain qualifier with no ready.
// Ports: in, mean, in_vld, clr (producer to detector); dev, dev_vld, alarm, evt_cnt (detector to consumer).
interface dev_alarm_if;
    import dev_alarm_pkg::*;

    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] mean;
    logic              in_vld;
    logic              clr;
    logic [DATA_W-1:0] dev;
    logic              dev_vld;
    logic              alarm;
    logic [CNT_W-1:0]  evt_cnt;

    modport master (
        output in, mean, in_vld, clr,
        input  dev, dev_vld, alarm, evt_cnt
    );

    modport slave (
        input  in, mean, in_vld, clr,
        output dev, dev_vld, alarm, evt_cnt
    );

endinterface

// File: rtl/dev_alarm_abs_diff4.sv
// Purpose: combinational absolute difference |a-b| of two 4-bit unsigned values.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a_i, b_i operands; d_o result (cannot overflow 4 bits).
module abs_diff4
    import dev_alarm_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] d_o
);

    assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/dev_alarm.sv
// Purpose: deviation alarm; flags |in-mean| outliers and raises/drops an alarm with hysteresis runs.
// Latency: 1 cycle from in_vld to dev/dev_vld and to the alarm level change.
// Backpressure: none; every in_vld sample is consumed the cycle it is presented.
// Ports: clk, rst (async active-high); bus (slave side of dev_alarm_if).
module dev_alarm
    import dev_alarm_pkg::*;
#(
    parameter int THRESH = 4,
    parameter int N_TRIG = 3,
    parameter int N_REL  = 2,
    parameter int WARMUP = 4
) (
    input  logic     clk,
    input  logic     rst,
    dev_alarm_if.slave bus
);

    localparam int WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP - 1);
    localparam logic [RUN_W-1:0]  TRIG_RUN  = RUN_W'(N_TRIG);
    localparam logic [RUN_W-1:0]  REL_RUN   = RUN_W'(N_REL);
    localparam logic [DATA_W-1:0] THR       = DATA_W'(THRESH);

    logic [DATA_W-1:0] diff;
    logic              outlier;

    state_t            state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, run_inc;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0]  evt_q, evt_d;
    logic              alarm_q, alarm_d;
    logic [DATA_W-1:0] dev_q;
    logic              dev_vld_q;

    abs_diff4 u_abs (
        .a_i (bus.in),
        .b_i (bus.mean),
        .d_o (diff)
    );

    assign outlier = (diff > THR);
    assign run_inc = run_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WARM;
            run_q     <= '0;
            warm_q    <= '0;
            evt_q     <= '0;
            alarm_q   <= 1'b0;
            dev_q     <= '0;
            dev_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            warm_q    <= warm_d;
            evt_q     <= evt_d;
            alarm_q   <= alarm_d;
            dev_vld_q <= bus.in_vld;
            if (bus.in_vld) begin
                dev_q <= diff;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        warm_d  = warm_q;
        evt_d   = evt_q;

        if (bus.in_vld) begin
            case (state_q)
                ST_WARM: begin
                    // Outliers are not evaluated until the upstream mean window has filled.
                    if (warm_q == WARM_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        warm_d = warm_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (outlier) begin
                        if (TRIG_RUN == RUN_W'(1)) begin
                            state_d = ST_ALARM;
                            run_d   = '0;
                            evt_d   = sat_inc(evt_q);
                        end else begin
                            state_d = ST_SUSPECT;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (outlier) begin
                        if (run_inc == TRIG_RUN) begin
                            state_d = ST_ALARM;
                            run_d   = '0;
                            evt_d   = sat_inc(evt_q);
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end
                end
                ST_ALARM: begin
                    if (!outlier) begin
                        if (REL_RUN == RUN_W'(1)) begin
                            state_d = ST_IDLE;
                            run_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!outlier) begin
                        if (run_inc == REL_RUN) begin
                            state_d = ST_IDLE;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        // Re-entry from RELEASE is the same alarm episode, so no new event.
                        state_d = ST_ALARM;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end

        // clr overrides any transition the current sample would have caused.
        if (bus.clr) begin
            state_d = ST_IDLE;
            run_d   = '0;
            evt_d   = '0;
        end

        alarm_d = (state_d == ST_ALARM) || (state_d == ST_RELEASE);
    end

    assign bus.dev     = dev_q;
    assign bus.dev_vld = dev_vld_q;
    assign bus.alarm   = alarm_q;
    assign bus.evt_cnt = evt_q;

endmodule

// File: tb/tb_dev_alarm.sv
// Purpose: self-checking bench for dev_alarm against a streak-count reference model.
// Latency: expects outputs one cycle after each driven sample.
// Backpressure: none exercised; the design has no ready.
module tb_dev_alarm;

    localparam int THRESH = 4;
    localparam int N_TRIG = 3;
    localparam int N_REL  = 2;
    localparam int WARMUP = 4;

    logic clk;
    logic rst;

    dev_alarm_if bus ();

    dev_alarm #(
        .THRESH (THRESH),
        .N_TRIG (N_TRIG),
        .N_REL  (N_REL),
        .WARMUP (WARMUP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: alarm is a boolean plus lengths of the current outlier / in-range streaks.
    int m_warm_left;
    bit m_alarm;
    int m_out_streak;
    int m_in_streak;
    int m_evt;
    int m_dev;
    int m_dev_vld;

    task automatic model_reset();
        m_warm_left  = WARMUP;
        m_alarm      = 1'b0;
        m_out_streak = 0;
        m_in_streak  = 0;
        m_evt        = 0;
        m_dev        = 0;
        m_dev_vld    = 0;
    endtask

    task automatic model_apply(input int a, input int b, input bit vld, input bit c);
        int d;
        bit is_out;
        d      = (a >= b) ? a - b : b - a;
        is_out = (d > THRESH);
        m_dev_vld = vld ? 1 : 0;
        if (vld) m_dev = d;
        if (c) begin
            m_alarm      = 1'b0;
            m_out_streak = 0;
            m_in_streak  = 0;
            m_evt        = 0;
            m_warm_left  = 0;
        end else if (vld) begin
            if (m_warm_left > 0) begin
                m_warm_left--;
            end else if (!m_alarm) begin
                if (is_out) begin
                    m_out_streak++;
                    if (m_out_streak >= N_TRIG) begin
                        m_alarm      = 1'b1;
                        m_out_streak = 0;
                        m_in_streak  = 0;
                        m_evt        = (m_evt < 255) ? m_evt + 1 : 255;
                    end
                end else begin
                    m_out_streak = 0;
                end
            end else begin
                if (!is_out) begin
                    m_in_streak++;
                    if (m_in_streak >= N_REL) begin
                        m_alarm      = 1'b0;
                        m_in_streak  = 0;
                        m_out_streak = 0;
                    end
                end else begin
                    m_in_streak = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_dev"},     int'(bus.dev),     m_dev);
        chk({tag, "_dev_vld"}, int'(bus.dev_vld), m_dev_vld);
        chk({tag, "_alarm"},   int'(bus.alarm),   int'(m_alarm));
        chk({tag, "_evt"},     int'(bus.evt_cnt), m_evt);
    endtask

    // Present one cycle of stimulus, then check outputs just after the capturing edge.
    task automatic step(input int a, input int b, input bit vld, input bit c, input string tag);
        @(negedge clk);
        bus.in     = 4'(a);
        bus.mean   = 4'(b);
        bus.in_vld = vld;
        bus.clr    = c;
        model_apply(a, b, vld, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in     = '0;
        bus.mean   = '0;
        bus.in_vld = 1'b0;
        bus.clr    = 1'b0;
        rst        = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Warm-up: four large deviations are ignored, the fifth only starts a streak.
        for (int i = 0; i < WARMUP; i++) step(15, 0, 1'b1, 1'b0, "warm");
        step(15, 0, 1'b1, 1'b0, "warm_5th");

        // dev equal to the threshold is not an outlier.
        for (int i = 0; i < 5; i++) step(9, 5, 1'b1, 1'b0, "boundary");

        // Three outliers raise the alarm on the cycle after the third.
        for (int i = 0; i < 3; i++) step(12, 5, 1'b1, 1'b0, "trigger");
        chk("trigger_alarm_is_1", int'(bus.alarm), 1);
        chk("trigger_evt_is_1",   int'(bus.evt_cnt), 1);

        // One in-range then an outlier keeps the alarm; two in-range drop it.
        step(5, 5, 1'b1, 1'b0, "rel_1");
        step(12, 5, 1'b1, 1'b0, "rel_back");
        step(5, 5, 1'b1, 1'b0, "rel_a");
        step(5, 5, 1'b1, 1'b0, "rel_b");
        chk("release_alarm_is_0", int'(bus.alarm), 0);

        // Broken outlier run never triggers.
        step(12, 5, 1'b1, 1'b0, "broken");
        step(12, 5, 1'b1, 1'b0, "broken");
        step(5, 5, 1'b1, 1'b0, "broken");
        step(12, 5, 1'b1, 1'b0, "broken");
        step(12, 5, 1'b1, 1'b0, "broken");
        step(5, 5, 1'b1, 1'b0, "broken");

        // Idle cycles hold dev.
        step(0, 15, 1'b0, 1'b0, "hold");
        step(0, 15, 1'b0, 1'b0, "hold");

        // Random traffic with occasional clr.
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                 ($urandom_range(3, 0) != 0), ($urandom_range(49, 0) == 0), "rnd");
        end

        // Saturate the event counter.
        step(0, 0, 1'b0, 1'b1, "sat_clr");
        for (int e = 0; e < 256; e++) begin
            for (int k = 0; k < 3; k++) step(12, 5, 1'b1, 1'b0, "sat");
            for (int k = 0; k < 2; k++) step(5, 5, 1'b1, 1'b0, "sat");
        end
        chk("sat_evt_255", int'(bus.evt_cnt), 255);

        // clr coincident with the would-be triggering sample wins; dev still updates.
        step(12, 5, 1'b1, 1'b0, "clr_race");
        step(12, 5, 1'b1, 1'b0, "clr_race");
        step(12, 5, 1'b1, 1'b1, "clr_race");
        chk("clr_race_dev_7",   int'(bus.dev), 7);
        chk("clr_race_alarm_0", int'(bus.alarm), 0);

        // After clr there is no warm-up: three outliers alarm immediately.
        for (int i = 0; i < 3; i++) step(3, 14, 1'b1, 1'b0, "post_clr");
        chk("post_clr_alarm_1", int'(bus.alarm), 1);

        // Asynchronous reset mid-alarm drops outputs before any clock edge.
        @(negedge clk);
        bus.in_vld = 1'b0;
        bus.clr    = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Warm-up restarts after reset.
        for (int i = 0; i < WARMUP + 3; i++) step(15, 1, 1'b1, 1'b0, "rewarm");
        step(0, 0, 1'b0, 1'b0, "tail");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dev_alarm.md
DEV_ALARM -- requirements
Module: dev_alarm

Interface
REQ-001 Parameter THRESH, default 4, deviation threshold; outlier when |in-mean| > THRESH (strict).
REQ-002 Parameter N_TRIG, default 3, consecutive outliers needed to raise alarm (range 1..15).
REQ-003 Parameter N_REL, default 2, consecutive in-range samples needed to drop alarm (range 1..15).
REQ-004 Parameter WARMUP, default 4, valid samples ignored by the FSM after reset (mean window fill).
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in  input  4  current raw sample, unsigned.
REQ-008 mean  input  4  running mean from the upstream mean stage, aligned to in.
REQ-009 in_vld  input  1  in/mean pair valid this cycle.
REQ-010 clr  input  1  synchronous clear of event counter and FSM.
REQ-011 dev  output  4  registered |in-mean| of last valid sample.
REQ-012 dev_vld  output  1  one-cycle pulse, dev updated.
REQ-013 alarm  output  1  registered alarm level.
REQ-014 evt_cnt  output  8  number of alarm rising edges since reset/clr.

Function
REQ-015 dev SHALL equal in-mean if in>=mean else mean-in, 4-bit, no overflow possible.
REQ-016 dev and dev_vld SHALL appear one cycle after the in_vld cycle (latency 1); dev holds between samples.
REQ-017 dev_vld SHALL pulse for every valid sample, including warm-up samples.
REQ-018 FSM states: WARM, IDLE, SUSPECT, ALARM, RELEASE; transitions only on in_vld cycles.
REQ-019 WARM: count valid samples; after WARMUP-th valid sample go IDLE; no outlier evaluation in WARM.
REQ-020 IDLE: outlier -> SUSPECT with run=1 (if N_TRIG=1 go directly ALARM); else stay.
REQ-021 SUSPECT: outlier -> run+1, reaching N_TRIG -> ALARM; in-range -> IDLE, run=0.
REQ-022 ALARM: in-range -> RELEASE with run=1 (if N_REL=1 go IDLE); outlier -> stay.
REQ-023 RELEASE: in-range -> run+1, reaching N_REL -> IDLE; outlier -> ALARM, run=0.
REQ-024 alarm SHALL be 1 in ALARM and RELEASE, 0 otherwise; registered, rises the cycle after the triggering sample.
REQ-025 evt_cnt SHALL increment on each entry to ALARM from SUSPECT/IDLE (not RELEASE->ALARM), saturating at 255.
REQ-026 clr (any cycle): state->IDLE (not WARM), run=0, alarm=0, evt_cnt=0; clr beats a simultaneous in_vld transition; dev/dev_vld still update for that sample.
REQ-027 Run counter 4 bits, cleared on every state change not listed as incrementing.

Reset
REQ-028 rst asserted: dev=0, dev_vld=0, alarm=0, evt_cnt=0, state=WARM, run=0, warm-up count=0, immediately (asynchronous).
REQ-029 Reset mid-ALARM SHALL drop alarm without waiting for a clock edge; warm-up restarts.

Structure
REQ-030 Shared package dev_alarm_pkg holds FSM state encoding constants and DATA_W=4, CNT_W=8.
REQ-031 One sub-module abs_diff4 (combinational |a-b|, 4-bit), instantiated once.

Verification (THRESH=4, N_TRIG=3, N_REL=2, WARMUP=4)
REQ-032 After reset, 4 valid samples in=15, mean=0 -> dev=15 each, alarm stays 0; 5th sample same -> still 0 (run=1).
REQ-033 Post warm-up, 3 valid samples in=12, mean=5 (dev=7) -> alarm=1 one cycle after the 3rd, evt_cnt=1.
REQ-034 Post warm-up, in=9, mean=5 (dev=4) x5 -> alarm stays 0 (boundary not outlier).
REQ-035 In ALARM: one sample dev=0 then dev=7 -> alarm stays 1, evt_cnt unchanged; then two dev=0 -> alarm=0.
REQ-036 Sequence outlier,outlier,in-range,outlier,outlier -> alarm never rises.
REQ-037 Force 256 alarm events -> evt_cnt=255; pulse clr together with a 3rd outlier -> evt_cnt=0, alarm=0; rst during ALARM -> alarm=0 before next edge.
